pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised successor to the 4-bit program counter.
- Adds configurable address width and reset vector, signed relative branch, and a hardware call/return stack with full/empty status and sticky error flags.
- Sits between the instruction decoder, which drives the control flags, and instruction memory, which is addressed by pc_out.

Parameters:
ADDR_W, 4, program counter and address width in bits (minimum 2).
STACK_DEPTH, 4, number of return-address entries (minimum 1).
RESET_ADDR, 0, value loaded into pc_out on reset (ADDR_W bits).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low.
busy  input  1  stall; holds pc_out and the stack unchanged.
jump_flag  input  1  absolute jump to jump_addr.
jump_addr  input  ADDR_W  target address for jump and call.
branch_flag  input  1  relative branch by branch_off.
branch_off  input  ADDR_W  signed two's-complement offset.
call_flag  input  1  push return address, then go to jump_addr.
ret_flag  input  1  pop return address into pc_out.
pc_out  output  ADDR_W  current program counter (registered).
stack_full  output  1  high when depth equals STACK_DEPTH.
stack_empty  output  1  high when depth equals 0.
stack_ovf  output  1  sticky: call attempted while full.
stack_unf  output  1  sticky: return attempted while empty.

Behaviour:
- Reset (rst low, asynchronous, immediate, no clock edge needed):
  - pc_out = RESET_ADDR, depth = 0.
  - stack_empty = 1, stack_full = 0, stack_ovf = 0, stack_unf = 0.
  - Stack RAM contents are don't-care.
- Release of rst takes effect on the first rising edge after rst goes high.
- Each rising edge applies exactly one action, chosen by priority busy > ret > call > jump > branch > increment:
  - busy=1: pc_out, depth and the stack are held. Sticky flags do not change. All other flags are ignored.
  - ret_flag=1 and depth>0: pc_out = stack[depth-1]; depth decrements.
  - ret_flag=1 and depth=0: pc_out = pc_out+1; stack_unf set to 1.
  - call_flag=1 and depth<STACK_DEPTH: stack[depth] = pc_out+1 (mod 2^ADDR_W); pc_out = jump_addr; depth increments.
  - call_flag=1 and depth=STACK_DEPTH: no push and no jump; pc_out = pc_out+1; stack_ovf set to 1.
  - jump_flag=1: pc_out = jump_addr.
  - branch_flag=1: pc_out = pc_out + sign-extended branch_off, modulo 2^ADDR_W.
  - Otherwise: pc_out = pc_out+1.
- Arithmetic: all pc arithmetic is ADDR_W bits and wraps; the maximum value plus 1 gives 0. There is no carry-out or error on wrap.
- Latency: one cycle. The new pc_out is visible after the edge that sampled the flags.
- Status outputs:
  - stack_full and stack_empty are combinational decodes of the registered depth.
  - Depth counter width is clog2(STACK_DEPTH+1).
  - stack_ovf and stack_unf clear only on reset.
- Simultaneous flags: lower-priority flags are dropped entirely in the same cycle. Example: call+jump performs only the call.
- Reset mid-stall or mid-call sequence: reset wins asynchronously, and the stack is logically emptied.

Test Plan:
- Reset/increment (ADDR_W=4, RESET_ADDR=0):
  - Hold rst low for 2 cycles -> pc_out=0, stack_empty=1.
  - Release for 17 edges -> pc_out runs 1..15, wraps to 0, then 1.
- Jump and branch:
  - At pc=3, jump_flag=1, jump_addr=10 for 1 cycle -> pc_out=10, then 11.
  - At pc=11, branch_flag=1, branch_off=4'b1101 (-3) -> pc_out=8.
  - At pc=14, branch_off=3 -> pc_out=1 (wrap).
- Call/return nesting:
  - At pc=2, call to 8 -> pc=8, depth=1.
  - At pc=9, call to 12 -> pc=12.
  - At pc=12, ret -> pc=10.
  - At pc=11, ret -> pc=3.
  - Then stack_empty=1 and both sticky flags remain 0.
- Overflow/underflow (STACK_DEPTH=4):
  - 4 calls -> stack_full=1. A 5th call at pc=P -> pc=P+1, stack_ovf=1, depth stays 4.
  - 4 rets return in LIFO order. A 5th ret -> pc increments, stack_unf=1.
  - Both flags stay high until rst goes low.
- Stall and priority:
  - busy=1 for 3 cycles with call_flag=1 -> pc_out and depth unchanged.
  - Then busy=0 with call_flag=1, jump_flag=1, branch_flag=1 -> only the call executes: pc=jump_addr, depth+1.
- Async reset mid-operation:
  - Assert rst low between edges with depth=2 -> pc_out=RESET_ADDR and stack_empty=1 immediately, before the next edge.
  - A ret after release -> stack_unf=1.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with absolute jump, signed relative branch and a hardware
// call/return stack with full/empty status and sticky overflow/underflow flags.
module pc_stack #(
  parameter int                ADDR_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              call_flag,
  input  logic              ret_flag,
  output logic [ADDR_W-1:0] pc_out,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0]  pc_reg, pc_next, pc_inc;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic               ovf_reg, ovf_next;
  logic               unf_reg, unf_next;
  logic               push;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  assign pc_inc      = pc_reg + 1'b1;
  assign wr_ptr      = PTR_W'(depth_reg);
  assign rd_ptr      = PTR_W'(depth_reg - 1'b1);
  assign stack_full  = (depth_reg == FULL_DEPTH);
  assign stack_empty = (depth_reg == '0);

  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push       = 1'b0;
    if (busy) begin
      pc_next = pc_reg;
    end else if (ret_flag) begin
      if (stack_empty) begin
        pc_next  = pc_inc;
        unf_next = 1'b1;
      end else begin
        pc_next    = stack_mem[rd_ptr];
        depth_next = depth_reg - 1'b1;
      end
    end else if (call_flag) begin
      if (stack_full) begin
        pc_next  = pc_inc;
        ovf_next = 1'b1;
      end else begin
        push       = 1'b1;
        pc_next    = jump_addr;
        depth_next = depth_reg + 1'b1;
      end
    end else if (jump_flag) begin
      pc_next = jump_addr;
    end else if (branch_flag) begin
      // Same-width modular add is identical to adding the sign-extended offset.
      pc_next = pc_reg + branch_off;
    end else begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg    <= RESET_ADDR;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack contents need no reset; emptiness is carried entirely by depth_reg.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      stack_mem[wr_ptr] <= pc_inc;
    end
  end

  assign pc_out    = pc_reg;
  assign stack_ovf = ovf_reg;
  assign stack_unf = unf_reg;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, async-reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_pc_stack;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int MOD    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              busy = 1'b0, jump_flag = 1'b0, branch_flag = 1'b0;
  logic              call_flag = 1'b0, ret_flag = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0, branch_off = '0;
  logic [ADDR_W-1:0] pc_out;
  logic              stack_full, stack_empty, stack_ovf, stack_unf;

  pc_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(4'd0)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .branch_flag(branch_flag), .branch_off(branch_off),
    .call_flag(call_flag), .ret_flag(ret_flag),
    .pc_out(pc_out), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy, ret, call, jump, branch;
    logic [3:0] jaddr, boff;
    int         pc, depth;
    logic       ovf, unf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int   m_pc;
  int   m_stk[$];
  logic m_ovf, m_unf;

  function automatic vec_t mk(logic b, logic r, logic c, logic j, logic br,
                              int ja, int bo, int pc, int d, logic ov, logic un);
    vec_t v;
    v.busy = b; v.ret = r; v.call = c; v.jump = j; v.branch = br;
    v.jaddr = 4'(ja); v.boff = 4'(bo);
    v.pc = pc; v.depth = d; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input int pc, input int d,
                           input logic ov, input logic un);
    check({tag, ".pc"}, int'(pc_out), pc);
    check({tag, ".full"}, int'(stack_full), (d == DEPTH) ? 1 : 0);
    check({tag, ".empty"}, int'(stack_empty), (d == 0) ? 1 : 0);
    check({tag, ".ovf"}, int'(stack_ovf), int'(ov));
    check({tag, ".unf"}, int'(stack_unf), int'(un));
  endtask

  task automatic drive(input logic b, input logic r, input logic c, input logic j,
                       input logic br, input logic [3:0] ja, input logic [3:0] bo);
    busy = b; ret_flag = r; call_flag = c; jump_flag = j; branch_flag = br;
    jump_addr = ja; branch_off = bo;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic b, input logic r, input logic c, input logic j,
                            input logic br, input int ja, input int bo);
    int o;
    if (b) begin
    end else if (r) begin
      if (m_stk.size() == 0) begin m_pc = (m_pc + 1) % MOD; m_unf = 1'b1; end
      else m_pc = m_stk.pop_back();
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin m_pc = (m_pc + 1) % MOD; m_ovf = 1'b1; end
      else begin m_stk.push_back((m_pc + 1) % MOD); m_pc = ja; end
    end else if (j) begin
      m_pc = ja;
    end else if (br) begin
      o = (bo >= MOD / 2) ? bo - MOD : bo;
      m_pc = ((m_pc + o) % MOD + MOD) % MOD;
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b1;

    // Directed table following the program-counter walk
    for (int i = 0; i < 17; i++) tbl.push_back(mk(0,0,0,0,0, 0,0, (i + 1) % 16, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0,  2, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0,  3, 0, 0,0));
    tbl.push_back(mk(0,0,0,1,0, 10,0, 10, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0, 11, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,13,  8, 0, 0,0));
    tbl.push_back(mk(0,0,0,1,0, 14,0, 14, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0, 3,  1, 0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0,  2, 0, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 8, 0,  8, 1, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0,  9, 1, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 12,0, 12, 2, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0, 10, 1, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 0, 11, 1, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0,  3, 0, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 5, 0,  5, 1, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 9, 0,  9, 2, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 13,0, 13, 3, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 0,  0, 4, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 7, 0,  1, 4, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0, 14, 3, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0, 10, 2, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0,  6, 1, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0,  4, 0, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 0,  5, 0, 1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,0,0, 9,0, 5, 0, 1,1));
    tbl.push_back(mk(0,0,1,1,1, 9, 2,  9, 1, 1,1));
    tbl.push_back(mk(0,1,0,0,0, 0, 0,  6, 0, 1,1));
    tbl.push_back(mk(0,0,0,0,0, 0, 0,  7, 0, 1,1));

    foreach (tbl[k]) begin
      drive(tbl[k].busy, tbl[k].ret, tbl[k].call, tbl[k].jump, tbl[k].branch,
            tbl[k].jaddr, tbl[k].boff);
      check_all($sformatf("vec%0d", k), tbl[k].pc, tbl[k].depth, tbl[k].ovf, tbl[k].unf);
    end

    // Asynchronous reset between edges with two entries on the stack
    drive(0,0,1,0,0, 4'd6, 4'd0);
    drive(0,0,1,0,0, 4'd11, 4'd0);
    check_all("pre_async", 11, 2, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    drive(0,1,0,0,0, 4'd0, 4'd0);
    check_all("ret_after_rst", 1, 0, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    rst = 1'b0;
    #3;
    rst = 1'b1;
    m_pc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic b, r, c, j, br;
      logic [3:0] ja, bo;
      b  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 3) == 0);
      ja = 4'($urandom_range(0, 15));
      bo = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        m_pc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end
      model_step(b, r, c, j, br, int'(ja), int'(bo));
      drive(b, r, c, j, br, ja, bo);
      check_all($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
